// File: rtl/ct_f_spsram_rmw_banked.sv
// Banked single-port SRAM wrapper with read-modify-write for bit-masked writes.
// Optional post-reset clear engine enabled by defining CT_F_SPSRAM_INIT_EN.
module ct_f_spsram_rmw_banked #(
  parameter int unsigned          ADDR_WIDTH = 11,
  parameter int unsigned          DATA_WIDTH = 128,
  parameter int unsigned          WRAP_SIZE  = 64,
  parameter logic [WRAP_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY,
  output logic                  INIT_DONE
);

  localparam int unsigned NSLICE = DATA_WIDTH / WRAP_SIZE;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

`ifdef CT_F_SPSRAM_INIT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RMW, ST_INIT} state_t;
  localparam state_t RST_STATE = ST_INIT;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RMW} state_t;
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_m;
  logic [NSLICE-1:0]     w_full;
  logic [NSLICE-1:0]     w_part;
  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic [ADDR_WIDTH-1:0] w_waddr;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_m;
  logic [NSLICE-1:0]     r_part;
`ifdef CT_F_SPSRAM_INIT_EN
  logic [ADDR_WIDTH-1:0] r_cnt;
`endif

  assign BUSY  = (r_state != ST_IDLE);
  assign w_m   = ~WEN;
  assign w_req = !CEN && !BUSY;
  assign w_wr  = w_req && !GWEN;
  assign w_rd  = w_req && GWEN;

  always_comb begin
    w_full = '0;
    w_part = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      w_full[s] = &w_m[s*WRAP_SIZE +: WRAP_SIZE];
      w_part[s] = (|w_m[s*WRAP_SIZE +: WRAP_SIZE]) && !w_full[s];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_wr && (|w_part)) w_state_nxt = ST_RMW;
      ST_RMW:  w_state_nxt = ST_IDLE;
`ifdef CT_F_SPSRAM_INIT_EN
      ST_INIT: if (r_cnt == '1) w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_addr <= '0;
      r_d    <= '0;
      r_m    <= '0;
      r_part <= '0;
    end else if (w_wr) begin
      r_addr <= A;
      r_d    <= D;
      r_m    <= w_m;
      r_part <= w_part;
    end
  end

`ifdef CT_F_SPSRAM_INIT_EN
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)                 r_cnt <= '0;
    else if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
  end
  assign INIT_DONE = (r_state != ST_INIT);
`else
  assign INIT_DONE = 1'b1;
`endif

  always_comb begin
    w_waddr = A;
    if (r_state == ST_RMW) w_waddr = r_addr;
`ifdef CT_F_SPSRAM_INIT_EN
    if (r_state == ST_INIT) w_waddr = r_cnt;
`endif
  end

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    logic [WRAP_SIZE-1:0] r_mem [DEPTH];
    logic [WRAP_SIZE-1:0] r_old;
    logic [WRAP_SIZE-1:0] r_q;
    logic [WRAP_SIZE-1:0] w_wdata;
    logic                 w_we;

    // Full-mask slices write in the request cycle; partial ones merge a cycle later.
    always_comb begin
      w_we    = 1'b0;
      w_wdata = D[s*WRAP_SIZE +: WRAP_SIZE];
      case (r_state)
        ST_IDLE: w_we = w_wr && w_full[s];
        ST_RMW: begin
          w_we    = r_part[s];
          w_wdata = (r_old & ~r_m[s*WRAP_SIZE +: WRAP_SIZE]) |
                    (r_d[s*WRAP_SIZE +: WRAP_SIZE] & r_m[s*WRAP_SIZE +: WRAP_SIZE]);
        end
`ifdef CT_F_SPSRAM_INIT_EN
        ST_INIT: begin
          w_we    = 1'b1;
          w_wdata = INIT_VALUE;
        end
`endif
        default: w_we = 1'b0;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      if (w_wr) r_old <= r_mem[A];
    end

    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B)    r_q <= '0;
      else if (w_rd) r_q <= r_mem[A];
    end

    assign Q[s*WRAP_SIZE +: WRAP_SIZE] = r_q;
  end

endmodule

// File: tb/tb_ct_f_spsram_rmw_banked.sv
// Directed and seeded-random checks of the banked RMW SRAM wrapper (ADDR_WIDTH=4).
// Expectations follow CT_F_SPSRAM_INIT_EN if it is defined for the build.
module tb_ct_f_spsram_rmw_banked;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 128;
  localparam int unsigned WS    = 64;
  localparam int unsigned DEPTH = 16;
`ifdef CT_F_SPSRAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          CLK   = 1'b0;
  logic          RST_B = 1'b0;
  logic [AW-1:0] A     = '0;
  logic          CEN   = 1'b1;
  logic          GWEN  = 1'b1;
  logic [DW-1:0] WEN   = '1;
  logic [DW-1:0] D     = '0;
  logic [DW-1:0] Q;
  logic          BUSY;
  logic          INIT_DONE;

  int unsigned   n_vec  = 0;
  int unsigned   n_miss = 0;
  logic [DW-1:0] mdl [DEPTH];

  always #5 CLK = ~CLK;

  ct_f_spsram_rmw_banked #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WRAP_SIZE (WS),
    .INIT_VALUE(64'h0)
  ) dut (
    .CLK      (CLK),
    .RST_B    (RST_B),
    .A        (A),
    .CEN      (CEN),
    .GWEN     (GWEN),
    .WEN      (WEN),
    .D        (D),
    .Q        (Q),
    .BUSY     (BUSY),
    .INIT_DONE(INIT_DONE)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input logic cen, input logic gwen, input logic [AW-1:0] a,
                    input logic [DW-1:0] wen, input logic [DW-1:0] d);
    CEN = cen; GWEN = gwen; A = a; WEN = wen; D = d;
    step();
    CEN = 1'b1; GWEN = 1'b1; WEN = '1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    op(1'b0, 1'b1, a, '1, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] wen, input logic [DW-1:0] d);
    op(1'b0, 1'b0, a, wen, d);
  endtask

  task automatic wait_init(input string tag);
    int unsigned n;
    n = 0;
    while (BUSY && n < 40) begin
      step();
      n++;
    end
    check(tag, n, INIT_EN ? 16 : 0);
    check({tag, "_done"}, INIT_DONE, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] m;
    logic [DW-1:0] d;
    logic [DW-1:0] q_exp;
    logic [WS-1:0] ms;
    logic          busy_exp;
    logic          nb;
    logic          cen;
    logic          gwen;
    logic [AW-1:0] a;

    step();
    step();
    check("rst_q", Q, '0);
    check("rst_busy", BUSY, INIT_EN);
    check("rst_done", INIT_DONE, !INIT_EN);
    RST_B = 1'b1;
    check("rel_busy", BUSY, INIT_EN);
    wait_init("init_len");
    if (!INIT_EN)
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), '0, '0);

    // Every address reads zero after the clear sweep / zero fill.
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i));
      check($sformatf("s1_rd%0d", i), Q, '0);
    end

    wr(4'd5, '0, '1);
    check("s2_busy_wr", BUSY, 1'b0);
    rd(4'd5);
    check("s2_busy_rd", BUSY, 1'b0);
    check("s2_q", Q, '1);
    wr(4'd6, '0, 128'h1234);
    check("s2_hold", Q, '1);

    wr(4'd3, ~128'hFF, '1);
    check("s3_busy", BUSY, 1'b1);
    wr(4'd7, '0, '1);
    check("s3_busy_clr", BUSY, 1'b0);
    rd(4'd3);
    check("s3_q", Q, 128'hFF);
    rd(4'd7);
    check("s3_ignored_wr", Q, '0);
    rd(4'd3);
    wr(4'd3, ~128'h0F, '0);
    check("s3b_busy", BUSY, 1'b1);
    rd(4'd5);
    check("s3b_ignored_rd", Q, 128'hFF);
    rd(4'd3);
    check("s3b_q", Q, 128'hF0);

    v = {{64{1'b1}}, 64'h1};
    wr(4'd9, ~v, '1);
    check("s4_busy", BUSY, 1'b1);
    step();
    rd(4'd9);
    check("s4_q", Q, v);

    wr(4'd10, ~128'hFF, '1);
    RST_B = 1'b0;
    #1;
    check("s5_q", Q, '0);
    check("s5_busy", BUSY, INIT_EN);
    check("s5_done", INIT_DONE, !INIT_EN);
    step();
    RST_B = 1'b1;
    wait_init("s5_init_len");
    rd(4'd10);
    check("s5_lost", Q, '0);
    rd(4'd3);
    check("s5_kept", Q, INIT_EN ? 128'h0 : 128'hF0);

    // Seeded random traffic against a word-level reference model.
    for (int i = 0; i < DEPTH; i++) begin
      wr(AW'(i), '0, '0);
      mdl[i] = '0;
    end
    rd(4'd0);
    q_exp = '0;
    check("rnd_start", Q, q_exp);
    busy_exp = 1'b0;
    for (int it = 0; it < 300; it++) begin
      cen  = ($urandom_range(0, 3) == 0);
      gwen = ($urandom_range(0, 1) == 1);
      a    = AW'($urandom_range(0, DEPTH - 1));
      d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      m    = '0;
      for (int s = 0; s < 2; s++) begin
        case ($urandom_range(0, 2))
          0:       ms = '0;
          1:       ms = '1;
          default: ms = {$urandom(), $urandom()};
        endcase
        m[s*WS +: WS] = ms;
      end
      nb = 1'b0;
      if (!cen && !busy_exp) begin
        if (gwen) q_exp = mdl[a];
        else begin
          mdl[a] = (mdl[a] & ~m) | (d & m);
          for (int s = 0; s < 2; s++) begin
            ms = m[s*WS +: WS];
            if (ms != '0 && ms != '1) nb = 1'b1;
          end
        end
      end
      busy_exp = nb;
      op(cen, gwen, a, ~m, d);
      check("rnd_q", Q, q_exp);
      check("rnd_busy", BUSY, busy_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
